// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART constants and FSM state encoding.
// Revision : 1.0
// ============================================================================
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_if
// Purpose  : Serial line input plus received-byte/status outputs of uart_rx.
// Revision : 1.0
// ============================================================================
interface uart_rx_if #(
  parameter int DATA_BITS = uart_pkg::DATA_BITS
);

  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_done;
  logic                 rx_frame_err;
  logic                 rx_busy;

  modport master (
    output rx,
    input  rx_data, rx_done, rx_frame_err, rx_busy
  );

  modport slave (
    input  rx,
    output rx_data, rx_done, rx_frame_err, rx_busy
  );

endinterface
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Purpose  : 1-bit two-flop synchronizer with parameterized reset value.
// Revision : 1.0
// ============================================================================
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic d,
  output logic      q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver, centre sampling, one-cycle done/error pulses.
// Revision : 1.0
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = uart_pkg::DATA_BITS
) (
  input wire logic  clk,
  input wire logic  rst_n,
  uart_rx_if.slave  bus
);

  localparam int             CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]     LAST_BIT = 3'(DATA_BITS - 1);

  logic                 w_rx_s;
  logic                 w_fall;
  logic                 w_cnt_last;
  logic                 w_cnt_half;
  uart_state_t          r_state;
  uart_state_t          w_state_next;
  logic                 r_rx_prev;
  logic [CW-1:0]        r_cnt;
  logic [2:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_done;
  logic                 r_frame_err;
  logic                 r_busy;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.rx),
    .q     (w_rx_s)
  );

  // Edge detector runs in every state so a start bit arriving right as STOP
  // hands back to IDLE is still seen on the first IDLE cycle.
  assign w_fall     = r_rx_prev & ~w_rx_s;
  assign w_cnt_last = (r_cnt == CNT_LAST);
  assign w_cnt_half = (r_cnt == CNT_HALF);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_fall) w_state_next = START;
      START:   if (w_cnt_half) w_state_next = w_rx_s ? IDLE : DATA;
      DATA:    if (w_cnt_last && (r_bit_idx == LAST_BIT)) w_state_next = STOP;
      STOP:    if (w_cnt_last) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rx_prev   <= 1'b1;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_rx_prev   <= w_rx_s;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= (w_state_next != IDLE);
      case (r_state)
        IDLE: begin
          r_cnt     <= '0;
          r_bit_idx <= '0;
        end
        START: begin
          if (w_cnt_half) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DATA: begin
          if (w_cnt_last) begin
            r_cnt   <= '0;
            r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            if (r_bit_idx != LAST_BIT) r_bit_idx <= r_bit_idx + 3'd1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        STOP: begin
          if (w_cnt_last) begin
            r_cnt <= '0;
            if (w_rx_s) begin
              r_data <= r_shift;
              r_done <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign bus.rx_data      = r_data;
  assign bus.rx_done      = r_done;
  assign bus.rx_frame_err = r_frame_err;
  assign bus.rx_busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Directed self-checking bench for uart_rx (16 and 17 clk/bit).
// Revision : 1.0
// ============================================================================
module tb_uart_rx;

  logic clk;
  logic rst_n;
  int   cyc;

  uart_rx_if i16 ();
  uart_rx_if i17 ();

  uart_rx #(.CLKS_PER_BIT(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(i16.slave));
  uart_rx #(.CLKS_PER_BIT(17)) dut17 (.clk(clk), .rst_n(rst_n), .bus(i17.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks;
  int   fails;
  int   done_cnt, err_cnt, busy_cyc, busy_rise, both_seen, last_done_cyc;
  int   done17_cnt, err17_cnt;
  int   frame_cyc;
  logic busy_prev;
  logic [7:0] cap[$];
  logic [7:0] cap17[$];

  typedef struct {
    logic [7:0] d;
    logic       stop;
    int         exp_done;
    int         exp_err;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  always @(negedge clk) begin
    if (i16.rx_done) begin
      done_cnt++;
      last_done_cyc = cyc;
      cap.push_back(i16.rx_data);
    end
    if (i16.rx_frame_err) err_cnt++;
    if (i16.rx_done && i16.rx_frame_err) both_seen++;
    if (i16.rx_busy) busy_cyc++;
    if (i16.rx_busy && !busy_prev) busy_rise++;
    busy_prev = i16.rx_busy;
    if (i17.rx_done) begin
      done17_cnt++;
      cap17.push_back(i17.rx_data);
    end
    if (i17.rx_frame_err) err17_cnt++;
    if (i17.rx_done && i17.rx_frame_err) both_seen++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clr_mon();
    done_cnt = 0; err_cnt = 0; busy_cyc = 0; busy_rise = 0;
    done17_cnt = 0; err17_cnt = 0;
    cap.delete();
    cap17.delete();
  endtask

  task automatic set_rx(input logic b);
    i16.rx = b;
    i17.rx = b;
  endtask

  task automatic idle(input int n);
    set_rx(1'b1);
    repeat (n) @(negedge clk);
  endtask

  // Bit edges are placed at round(k*per) cycles from the start edge so that
  // non-integer bit periods (baud skew) accumulate realistically.
  task automatic send_frame(input logic [7:0] d, input logic stop, input real per);
    logic [9:0] bits;
    int e;
    int t;
    bits = {stop, d, 1'b0};
    frame_cyc = cyc;
    e = 0;
    for (int i = 0; i < 10; i++) begin
      set_rx(bits[i]);
      t = $rtoi((i + 1) * per + 0.5);
      while (e < t) begin
        @(negedge clk);
        e++;
      end
    end
  endtask

  initial begin
    int c0;
    checks = 0; fails = 0; both_seen = 0; busy_prev = 1'b0;
    clr_mon();

    vecs[0] = '{8'h01, 1'b1, 1, 0, 8'h01};
    vecs[1] = '{8'h80, 1'b1, 1, 0, 8'h80};
    vecs[2] = '{8'h3C, 1'b0, 0, 1, 8'h80};
    vecs[3] = '{8'h5A, 1'b1, 1, 0, 8'h5A};
    vecs[4] = '{8'hC3, 1'b0, 0, 1, 8'h5A};
    vecs[5] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vecs[6] = '{8'hFE, 1'b1, 1, 0, 8'hFE};

    rst_n = 1'b0;
    set_rx(1'b1);
    repeat (4) @(negedge clk);
    check("reset rx_data", {24'h0, i16.rx_data}, 32'h00);
    check("reset rx_done", {31'h0, i16.rx_done}, 32'h0);
    check("reset rx_frame_err", {31'h0, i16.rx_frame_err}, 32'h0);
    check("reset rx_busy", {31'h0, i16.rx_busy}, 32'h0);
    rst_n = 1'b1;
    idle(10);

    // 0xA5: data, exact latency and continuous busy
    clr_mon();
    send_frame(8'hA5, 1'b1, 16.0);
    idle(40);
    check("a5 rx_data", {24'h0, i16.rx_data}, 32'hA5);
    check("a5 done count", done_cnt, 1);
    check("a5 err count", err_cnt, 0);
    check("a5 done latency", last_done_cyc - frame_cyc, 155);
    check("a5 busy cycles", busy_cyc, 152);
    check("a5 busy rises", busy_rise, 1);

    // 5-cycle glitch: rejected at the start-bit centre sample
    clr_mon();
    c0 = cyc;
    set_rx(1'b0);
    repeat (5) @(negedge clk);
    set_rx(1'b1);
    repeat (5) @(negedge clk);
    check("glitch busy before start sample", {31'h0, i16.rx_busy}, 32'h1);
    @(negedge clk);
    check("glitch cycle count", cyc - c0, 11);
    check("glitch busy after start sample", {31'h0, i16.rx_busy}, 32'h0);
    idle(20);
    check("glitch done count", done_cnt, 0);
    check("glitch err count", err_cnt, 0);
    check("glitch rx_data", {24'h0, i16.rx_data}, 32'hA5);

    // 0x3C with low stop bit, line then held in break
    clr_mon();
    send_frame(8'h3C, 1'b0, 16.0);
    set_rx(1'b0);
    repeat (100) @(negedge clk);
    check("break err count", err_cnt, 1);
    check("break done count", done_cnt, 0);
    check("break rx_data", {24'h0, i16.rx_data}, 32'hA5);
    check("break busy", {31'h0, i16.rx_busy}, 32'h0);
    idle(40);
    check("break release busy rises", busy_rise, 1);
    check("break release err count", err_cnt, 1);

    // back-to-back frames with no idle between
    clr_mon();
    send_frame(8'h55, 1'b1, 16.0);
    send_frame(8'hFF, 1'b1, 16.0);
    idle(40);
    check("b2b done count", done_cnt, 2);
    check("b2b first byte", (cap.size() > 0) ? {24'h0, cap[0]} : 32'hDEAD, 32'h55);
    check("b2b second byte", (cap.size() > 1) ? {24'h0, cap[1]} : 32'hDEAD, 32'hFF);
    check("b2b err count", err_cnt, 0);

    for (int i = 0; i < 7; i++) begin
      clr_mon();
      send_frame(vecs[i].d, vecs[i].stop, 16.0);
      idle(40);
      check($sformatf("vec%0d done count", i), done_cnt, vecs[i].exp_done);
      check($sformatf("vec%0d err count", i), err_cnt, vecs[i].exp_err);
      check($sformatf("vec%0d rx_data", i), {24'h0, i16.rx_data}, {24'h0, vecs[i].exp_data});
    end

    // reset during data bit 4 of 0x81, held until the frame is over
    clr_mon();
    fork
      send_frame(8'h81, 1'b1, 16.0);
      begin
        repeat (88) @(negedge clk);
        rst_n = 1'b0;
      end
    join
    check("abort rx_data cleared", {24'h0, i16.rx_data}, 32'h00);
    check("abort busy", {31'h0, i16.rx_busy}, 32'h0);
    rst_n = 1'b1;
    idle(40);
    check("abort no pulse", done_cnt + err_cnt, 0);
    send_frame(8'h81, 1'b1, 16.0);
    idle(40);
    check("resend done count", done_cnt, 1);
    check("resend rx_data", {24'h0, i16.rx_data}, 32'h81);
    check("resend err count", err_cnt, 0);

    // 17 clk/bit receiver with -3% and +3% stimulus
    idle(60);
    clr_mon();
    send_frame(8'h00, 1'b1, 16.49);
    send_frame(8'hFF, 1'b1, 16.49);
    idle(60);
    send_frame(8'h00, 1'b1, 17.51);
    send_frame(8'hFF, 1'b1, 17.51);
    idle(60);
    check("skew done count", done17_cnt, 4);
    check("skew fast 0x00", (cap17.size() > 0) ? {24'h0, cap17[0]} : 32'hDEAD, 32'h00);
    check("skew fast 0xFF", (cap17.size() > 1) ? {24'h0, cap17[1]} : 32'hDEAD, 32'hFF);
    check("skew slow 0x00", (cap17.size() > 2) ? {24'h0, cap17[2]} : 32'hDEAD, 32'h00);
    check("skew slow 0xFF", (cap17.size() > 3) ? {24'h0, cap17[3]} : 32'hDEAD, 32'hFF);
    check("skew err count", err17_cnt, 0);

    check("done and frame_err together", both_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
